// File: rtl/control_unit.sv
// control_unit: Moore main-control FSM for a multicycle RV32I-style datapath
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        IorD,
    output logic [1:0]  ALUSrcB,
    output logic        ALUSrcA,
    output logic [1:0]  PCSource,
    output logic        RegDst,
    output logic [1:0]  ALUOp
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        R_EXEC    = 4'd2,
        I_EXEC    = 4'd3,
        U_EXEC    = 4'd4,
        ALU_WB    = 4'd5,
        MEM_ADDR  = 4'd6,
        MEM_READ  = 4'd7,
        LOAD_WB   = 4'd8,
        MEM_WRITE = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = instruction[6:0];
    assign unused_bits = ^instruction[31:7];

    // state register; reset aborts any instruction in flight and restarts at FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // next-state: opcode dispatch in DECODE, load/store split re-read in MEM_ADDR
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:              state_d = R_EXEC;
                    OP_I:              state_d = I_EXEC;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JUMP;
                    OP_LUI, OP_AUIPC:  state_d = U_EXEC;
                    default:           state_d = FETCH;
                endcase
            end
            R_EXEC, I_EXEC, U_EXEC: state_d = ALU_WB;
            MEM_ADDR: state_d = (opcode == OP_LOAD)  ? MEM_READ :
                                (opcode == OP_STORE) ? MEM_WRITE : FETCH;
            MEM_READ: state_d = LOAD_WB;
            default:  state_d = FETCH;
        endcase
    end

    // Moore outputs decoded from the state alone; anything not driven stays 0
    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        IorD        = 1'b0;
        ALUSrcB     = 2'b00;
        ALUSrcA     = 1'b0;
        PCSource    = 2'b00;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
            end
            DECODE:    ALUSrcB = 2'b11;
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b10;
            end
            U_EXEC: begin
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            ALU_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            LOAD_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench checking every state's control word for each opcode class
module tb_control_unit;
    logic        clk, rst;
    logic [31:0] instruction;
    logic        PCWriteCond, PCWrite, RegWrite, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, IorD, ALUSrcA, RegDst;
    logic [1:0]  ALUSrcB, PCSource, ALUOp;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] word;
        string       tag;
    } exp_t;
    exp_t sb[$];

    // {PCWriteCond,PCWrite,RegWrite,MemRead,MemWrite,IRWrite,MemtoReg,IorD,ALUSrcB,ALUSrcA,PCSource,RegDst,ALUOp}
    localparam logic [15:0] W_FETCH  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b01,1'b0,2'b00,1'b0,2'b00};
    localparam logic [15:0] W_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,1'b0,2'b00};
    localparam logic [15:0] W_REXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,1'b0,2'b10};
    localparam logic [15:0] W_IEXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b00,1'b0,2'b10};
    localparam logic [15:0] W_UEXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,2'b00,1'b0,2'b11};
    localparam logic [15:0] W_ALUWB  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b00};
    localparam logic [15:0] W_MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b00,1'b0,2'b00};
    localparam logic [15:0] W_MREAD  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,2'b00};
    localparam logic [15:0] W_LDWB   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00};
    localparam logic [15:0] W_MWRITE = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,2'b00};
    localparam logic [15:0] W_BRANCH = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b01,1'b0,2'b01};
    localparam logic [15:0] W_JUMP   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,1'b0,2'b00};

    wire [15:0] obs = {PCWriteCond, PCWrite, RegWrite, MemRead, MemWrite, IRWrite, MemtoReg, IorD,
                       ALUSrcB, ALUSrcA, PCSource, RegDst, ALUOp};

    control_unit dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .IorD(IorD), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA),
        .PCSource(PCSource), .RegDst(RegDst), .ALUOp(ALUOp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input logic [15:0] o, input logic [15:0] e, input string tag);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
        compared++;
        assert (!(MemRead && MemWrite) && !(PCWrite && PCWriteCond)) else begin
            mismatched++;
            $error("FAIL %s_exclusive observed=%b expected=no MemRead&MemWrite, no PCWrite&PCWriteCond", tag, o);
        end
    endtask

    function automatic void push(input logic [15:0] w, input string tag);
        exp_t e;
        e.word = w;
        e.tag  = tag;
        sb.push_back(e);
    endfunction

    // expected state walk from DECODE back to FETCH for one instruction word
    function automatic void push_path(input logic [31:0] ins, input string tag);
        logic [6:0] op;
        op = ins[6:0];
        push(W_DECODE, {tag, "_decode"});
        case (op)
            7'b0110011: begin push(W_REXEC, {tag, "_exec"}); push(W_ALUWB, {tag, "_wb"}); end
            7'b0010011: begin push(W_IEXEC, {tag, "_exec"}); push(W_ALUWB, {tag, "_wb"}); end
            7'b0110111,
            7'b0010111: begin push(W_UEXEC, {tag, "_exec"}); push(W_ALUWB, {tag, "_wb"}); end
            7'b0000011: begin
                push(W_MADDR, {tag, "_addr"}); push(W_MREAD, {tag, "_read"}); push(W_LDWB, {tag, "_wb"});
            end
            7'b0100011: begin push(W_MADDR, {tag, "_addr"}); push(W_MWRITE, {tag, "_write"}); end
            7'b1100011: push(W_BRANCH, {tag, "_branch"});
            7'b1101111: push(W_JUMP, {tag, "_jump"});
            default: ;
        endcase
        push(W_FETCH, {tag, "_fetch"});
    endfunction

    // one clock per scoreboard entry, sampled 1 time unit after the edge
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(obs, e.word, e.tag);
        end
    endtask

    task automatic run(input logic [31:0] ins, input string tag);
        instruction = ins;
        push_path(ins, tag);
        drain();
    endtask

    initial begin
        rst = 1'b0;
        instruction = 32'h0;
        #3 rst = 1'b1;
        #1 check(obs, W_FETCH, "async_reset");
        @(posedge clk);
        #1 check(obs, W_FETCH, "reset_held");
        instruction = 32'h002080B3;
        push_path(instruction, "rtype");
        @(negedge clk);
        rst = 1'b0;
        drain();
        run(32'h00100093, "itype");
        run(32'h00D36363, "branch");
        run(32'h02853623, "store");
        run(32'h00002083, "load");
        run(32'hFFDFF06F, "jal");
        run(32'h000010B7, "lui");
        run(32'h00000017, "auipc");
        run(32'h00001245, "illegal");
        instruction = 32'h00002083;
        push(W_DECODE, "abort_decode");
        push(W_MADDR, "abort_addr");
        drain();
        #2 rst = 1'b1;
        #1 check(obs, W_FETCH, "midinstr_reset");
        @(negedge clk);
        rst = 1'b0;
        run(32'h02853623, "post_reset_store");
        run(32'h002080B3, "rtype_again");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
